// File: rtl/dff_ctrl_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding and
// default parameter values.
package dff_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int N_DEF        = 4;
  localparam int WIDTH_DEF    = 8;
  localparam int MAX_HOLD_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit searched from
// (last+1) mod N, wrapping around to last itself.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] cand;

  // k runs to N so the previous owner is the last candidate, giving re-grant.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time write access to a
// single shared register, with a bounded hold time per grant.
module shared_reg_arbiter
  import dff_ctrl_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N-1:0]       REQ,
  input  logic [N*WIDTH-1:0] DIN,
  output logic [N-1:0]       GNT,
  output logic [WIDTH-1:0]   Q,
  output logic               VALID
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t      state;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   last;
  logic [HW-1:0]   hold;

  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic [N-1:0]    pick_onehot;
  logic [WIDTH-1:0] slices [N];
  logic [WIDTH-1:0] din_g;
  logic            req_g;
  logic            load;
  logic            at_max;
  logic            release_now;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign slices[i] = DIN[i*WIDTH +: WIDTH];
  end

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (REQ),
    .last  (last),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign pick_onehot = N'(1) << pick_idx;
  assign din_g       = slices[gidx];
  assign req_g       = REQ[gidx];
  assign load        = (state == BUSY) && req_g;
  assign at_max      = (hold == HW'(MAX_HOLD));
  assign release_now = (state == BUSY) && (!req_g || at_max);

  // Control FSM; in BUSY, last equals the owner so the pick also covers re-grant.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      GNT   <= '0;
      gidx  <= '0;
      hold  <= '0;
      last  <= IW'(N - 1);
      VALID <= 1'b0;
    end else begin
      VALID <= load;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= BUSY;
            GNT   <= pick_onehot;
            gidx  <= pick_idx;
            last  <= pick_idx;
            hold  <= HW'(1);
          end
        end
        BUSY: begin
          if (release_now) begin
            if (pick_found) begin
              GNT  <= pick_onehot;
              gidx <= pick_idx;
              last <= pick_idx;
              hold <= HW'(1);
            end else begin
              state <= IDLE;
              GNT   <= '0;
              hold  <= '0;
            end
          end else begin
            hold <= hold + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The only datapath storage: the shared register with load enable.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Q <= '0;
    end else if (load) begin
      Q <= din_g;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (N=4, WIDTH=8, MAX_HOLD=4) with a
// scoreboard queue of expected shared-register loads.
`timescale 1ns/1ps
module tb_shared_reg_arbiter;

  logic        CLK;
  logic        RESET;
  logic [3:0]  REQ;
  logic [31:0] DIN;
  logic [3:0]  GNT;
  logic [7:0]  Q;
  logic        VALID;

  int total;
  int bad;
  logic [7:0] sb [$];

  shared_reg_arbiter #(.N(4), .WIDTH(8), .MAX_HOLD(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .REQ   (REQ),
    .DIN   (DIN),
    .GNT   (GNT),
    .Q     (Q),
    .VALID (VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_slice(input int i);
    sb.push_back(DIN[i*8 +: 8]);
  endtask

  task automatic tick(input string tag, input logic [3:0] eg, input logic ev);
    logic [7:0] eq;
    @(posedge CLK);
    #1;
    chk({tag, "_gnt"}, {28'd0, GNT}, {28'd0, eg});
    chk({tag, "_valid"}, {31'd0, VALID}, {31'd0, ev});
    if (ev) begin
      eq = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      chk({tag, "_q"}, {24'd0, Q}, {24'd0, eq});
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    REQ   = 4'b0000;
    sb.delete();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    REQ   = 4'b0000;
    DIN   = 32'h0;
    RESET = 1'b1;
    #1 RESET = 1'b0;
    #1;
    chk("rst_gnt", {28'd0, GNT}, 32'd0);
    chk("rst_q", {24'd0, Q}, 32'd0);
    chk("rst_valid", {31'd0, VALID}, 32'd0);
    do_reset();

    // First grant after reset, then asynchronous reset mid-grant
    DIN = 32'h33_22_11_A5;
    REQ = 4'b0001;
    tick("first", 4'b0001, 1'b0);
    push_slice(0);
    tick("first_load", 4'b0001, 1'b1);
    RESET = 1'b0;
    #0.5;
    chk("async_gnt", {28'd0, GNT}, 32'd0);
    chk("async_q", {24'd0, Q}, 32'd0);
    chk("async_valid", {31'd0, VALID}, 32'd0);
    do_reset();

    // All four requesting: 4 cycles each, no idle gap, load at every edge
    DIN = 32'h44_33_22_11;
    REQ = 4'b1111;
    tick("rr_k1", 4'b0001, 1'b0);
    for (int k = 2; k <= 17; k++) begin
      push_slice(((k - 2) / 4) % 4);
      tick($sformatf("rr_k%0d", k), 4'b0001 << (((k - 1) / 4) % 4), 1'b1);
    end

    // Drop all requests while busy
    REQ = 4'b0000;
    tick("drop_all", 4'b0000, 1'b0);
    chk("drop_all_q", {24'd0, Q}, 32'h44);

    // Lone requester 2 held: continuous re-grant, Q follows slice 2 only
    REQ = 4'b0100;
    DIN = 32'h01_02_03_04;
    tick("solo_grant", 4'b0100, 1'b0);
    for (int c = 0; c < 10; c++) begin
      DIN = $urandom;
      push_slice(2);
      tick($sformatf("solo_c%0d", c), 4'b0100, 1'b1);
    end
    REQ = 4'b0000;
    tick("solo_end", 4'b0000, 1'b0);

    // Owner 0 drops in hold cycle 2 with requester 2 pending
    DIN = 32'h00_00_00_5A;
    REQ = 4'b0001;
    tick("early_grant", 4'b0001, 1'b0);
    REQ = 4'b0101;
    push_slice(0);
    tick("early_load", 4'b0001, 1'b1);
    DIN = 32'h00_C3_00_99;
    REQ = 4'b0100;
    tick("early_switch", 4'b0100, 1'b0);
    chk("early_switch_q", {24'd0, Q}, 32'h5A);
    push_slice(2);
    tick("early_new", 4'b0100, 1'b1);
    REQ = 4'b0000;
    tick("early_end", 4'b0000, 1'b0);

    // Owner drops exactly at hold expiry: single release, no load
    DIN = 32'h00_00_77_10;
    REQ = 4'b0001;
    tick("exp_grant", 4'b0001, 1'b0);
    for (int h = 2; h <= 4; h++) begin
      DIN[7:0] = 8'(8'h10 + h);
      push_slice(0);
      tick($sformatf("exp_h%0d", h), 4'b0001, 1'b1);
    end
    DIN[7:0] = 8'hEE;
    REQ = 4'b0010;
    tick("exp_release", 4'b0010, 1'b0);
    chk("exp_release_q", {24'd0, Q}, 32'h14);
    REQ = 4'b0000;
    tick("exp_end", 4'b0000, 1'b0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, data width of the shared register.
REQ-003 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles per requester (>=1).
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RESET  input  1  reset, asynchronous and active-low: RESET=0 clears all state immediately, independent of CLK.
REQ-006 REQ  input  N  per-requester request, level-sensitive.
REQ-007 DIN  input  N*WIDTH  packed write data; slice i = DIN[i*WIDTH +: WIDTH].
REQ-008 GNT  output  N  registered one-hot-or-zero grant.
REQ-009 Q  output  WIDTH  shared register contents.
REQ-010 VALID  output  1  registered pulse: Q was loaded at the previous edge.

Function
REQ-011 States SHALL be IDLE (GNT=0) and BUSY (exactly one GNT bit high).
REQ-012 IDLE: on any edge with REQ!=0, SHALL enter BUSY with GNT set to the first requester with REQ high, searched round-robin from (LAST+1) mod N; latency REQ->GNT is 1 edge.
REQ-013 LAST SHALL update to the granted index at every grant, including a re-grant.
REQ-014 BUSY, granted g: at each edge where REQ[g]=1, Q SHALL load DIN slice g and VALID SHALL be 1 in the following cycle; otherwise VALID SHALL be 0.
REQ-015 Hold counter SHALL be 1 in the first grant cycle, increment each BUSY cycle, and saturate at no value beyond MAX_HOLD.
REQ-016 Release SHALL occur at the edge where REQ[g]=0 is sampled, or at the edge ending grant cycle MAX_HOLD.
REQ-017 At release, if another REQ bit is high, GNT SHALL switch directly to the round-robin winner at that same edge (no idle cycle); otherwise go IDLE.
REQ-018 At MAX_HOLD expiry with REQ[g]=1 and no other request, g SHALL be re-granted immediately with the hold counter restarted at 1.
REQ-019 At MAX_HOLD expiry with REQ[g]=1, Q SHALL still load DIN slice g at that edge.
REQ-020 REQ[g]=0 sampled coincident with MAX_HOLD expiry SHALL be treated as a single release, with no load.
REQ-021 REQ bits not currently granted SHALL never affect Q.
REQ-022 DIN slices of non-granted requesters SHALL be ignored.

Reset
REQ-023 RESET=0 SHALL force GNT=0, Q=0, VALID=0, state=IDLE, hold counter=0, LAST=N-1 (requester 0 wins first), asynchronously.
REQ-024 Assertion of RESET mid-grant SHALL abort the grant with no partial load.
REQ-025 The first grant after RESET deasserts SHALL follow REQ-012 at the first edge with RESET=1.

Structure
REQ-026 A shared package dff_ctrl_pkg SHALL hold the state encodings (IDLE=1'b0, BUSY=1'b1) and default parameter constants.
REQ-027 A sub-module rr_pick (combinational round-robin pick: REQ, LAST -> index, found) SHALL be instantiated once.
REQ-028 Q SHALL be one WIDTH-bit register with async active-low clear and load enable; there SHALL be no other datapath storage.

Verification (N=4, WIDTH=8, MAX_HOLD=4, 10 ns clock)
REQ-029 REQ=0001 during a grant, then RESET=0 at an edge+1 ns -> GNT=0000, Q=00, VALID=0 within the same ns, before any clock edge.
REQ-030 After reset: REQ=0001, slice0=A5 -> GNT=0001 after edge 1; Q=A5 and VALID=1 after edge 2.
REQ-031 REQ=1111 held -> GNT sequence 0001,0010,0100,1000,0001, 4 cycles each, no zero cycle between grants.
REQ-032 Only REQ=0100 held 10 cycles -> GNT stays 0100 throughout; Q tracks slice2 every edge; VALID continuously 1.
REQ-033 Grant 0001 active, REQ2 pending, REQ0 drops in hold cycle 2 -> GNT becomes 0100 at that edge; Q keeps the last slice0 value.
REQ-034 REQ=0000 in BUSY -> GNT=0000 next edge; VALID=0; Q unchanged.
